// File: rtl/serial_adder_disp.sv
// serial_adder_disp: debounced key-entry bit-serial adder with muxed hex display (SERIAL_ADDER_SUB_EN adds op_sub)
module serial_adder_disp #(
  parameter int WIDTH = 8,
  parameter int DB_CYCLES = 50000,
  parameter int SCAN_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load_n,
  input  logic             key_calc_n,
  input  logic             key_clr_n,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             op_sub,
`endif
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done,
  output logic [8:0]       seg_out,
  output logic [WIDTH/4:0] dig_sel
);
  localparam int NDIG = WIDTH / 4 + 1;
  localparam int DW = $clog2(DB_CYCLES);
  localparam int BW = $clog2(WIDTH);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int IW = $clog2(NDIG);
  localparam logic [6:0] FONT [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                       7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};
  typedef enum logic [1:0] {IDLE, CALC, RESULT} state_t;
  state_t state, nxt;
  logic [2:0] raw, stab, ev;
  logic [DW-1:0] dcnt [3];
  logic ev_load, ev_calc, ev_clr;
  logic [WIDTH-1:0] opa, opb, ra, rb, res;
  logic [WIDTH:0] disp_val;
  logic [4*NDIG-1:0] dv;
  logic [BW-1:0] bcnt;
  logic [SW-1:0] scnt;
  logic [IW-1:0] idx;
  logic c, s, cn, tog, last, sub;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub = op_sub;
`else
  assign sub = 1'b0;
`endif
  assign raw = {key_clr_n, key_calc_n, key_load_n};
  assign {ev_clr, ev_calc, ev_load} = ev;
  // stable level is 1 when released; an event fires only on the settle-to-pressed flip
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        stab[i] <= 1'b1;
        ev[i] <= 1'b0;
        dcnt[i] <= '0;
      end else begin
        ev[i] <= 1'b0;
        if (raw[i] != stab[i]) begin
          if (dcnt[i] == DW'(DB_CYCLES - 1)) begin
            stab[i] <= raw[i];
            ev[i] <= ~raw[i];
            dcnt[i] <= '0;
          end else
            dcnt[i] <= dcnt[i] + 1'b1;
        end else
          dcnt[i] <= '0;
      end
    end
  end
  assign s = ra[0] ^ rb[0] ^ c;
  assign cn = (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));
  assign last = bcnt == BW'(WIDTH - 1);
  always_comb
    nxt = ev_clr ? IDLE : state == CALC ? (last ? RESULT : CALC) :
          ev_calc ? CALC : ev_load ? IDLE : state;
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      {opa, opb, ra, rb, res, sum, disp_val, bcnt} <= '0;
      {c, cout, busy, done, tog} <= '0;
    end else begin
      done <= 1'b0;
      if (ev_clr) begin
        {opa, opb, sum, disp_val} <= '0;
        {cout, tog, busy} <= '0;
      end else if (state == CALC) begin
        ra <= ra >> 1;
        rb <= rb >> 1;
        c <= cn;
        res <= {s, res[WIDTH-1:1]};
        bcnt <= bcnt + 1'b1;
        if (last) begin
          sum <= {s, res[WIDTH-1:1]};
          cout <= cn;
          disp_val <= {cn, s, res[WIDTH-1:1]};
          done <= 1'b1;
          busy <= 1'b0;
        end
      end else if (ev_calc) begin
        ra <= opa;
        rb <= sub ? ~opb : opb;
        c <= sub;
        bcnt <= '0;
        busy <= 1'b1;
      end else if (ev_load) begin
        if (tog) opb <= data_in;
        else opa <= data_in;
        disp_val <= {1'b0, data_in};
        tog <= ~tog;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt <= '0;
      idx <= '0;
    end else if (scnt == SW'(SCAN_DIV - 1)) begin
      scnt <= '0;
      idx <= idx == IW'(NDIG - 1) ? '0 : idx + 1'b1;
    end else
      scnt <= scnt + 1'b1;
  end
  assign dv = {3'b000, disp_val};
  assign dig_sel = NDIG'(1) << idx;
  assign seg_out = {2'b00, FONT[dv[4*idx +: 4]]};
endmodule

// File: doc/serial_adder_disp.md
Name: serial_adder_disp

Overview:
- Parametrised successor to the 4-bit key-entry adder.
- Two WIDTH-bit operands are entered from switches with a debounced load key. A calc key starts a bit-serial ripple add using one full-adder cell over WIDTH cycles.
- Operands and result are shown on a time-multiplexed hex seven-segment bank.
- Sits between the board switches/keys and the display pins.

Parameters:
- WIDTH, 8: operand width in bits; multiple of 4, range 4..32.
- DB_CYCLES, 50000: cycles a key must be stable low to count as one press; minimum 2.
- SCAN_DIV, 1000: cycles each digit is driven before the scan advances; minimum 1.
- NDIG, WIDTH/4+1: derived, not overridable. One hex digit per nibble plus one carry digit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- key_load_n  in  1  load key, active-low, raw/bouncy
- key_calc_n  in  1  calculate key, active-low, raw/bouncy
- key_clr_n  in  1  clear key, active-low, raw/bouncy
- data_in  in  WIDTH  operand switches
- sum  out  WIDTH  registered sum
- cout  out  1  registered carry/borrow-out
- busy  out  1  high while in CALC
- done  out  1  one-cycle pulse when the result is written
- seg_out  out  9  active-high segments {dp,g..a}; hex font 0..F (0=9'h03f .. F=9'h071), dp always 0
- dig_sel  out  NDIG  one-hot digit enable; bit 0 is the rightmost digit

Behaviour:
- Reset (rst=1 at a clk edge), all synchronous:
  - opa, opb, sum, cout, disp_val, scan index and scan counter = 0; busy=0, done=0; state=IDLE.
  - Entry toggle = A; dig_sel=1; seg_out=9'h03f.
  - Debounce counters cleared and key state = released.
- Debounce, per key:
  - Counter runs while raw level differs from the stable state and clears otherwise.
  - Stable state flips when the counter reaches DB_CYCLES-1.
  - A high-to-low transition of the stable state produces a one-cycle event: ev_load, ev_calc or ev_clr.
  - Holding a key produces exactly one event.
- Event priority in the same cycle: ev_clr > ev_calc > ev_load.
- FSM states: IDLE, CALC, RESULT.
- IDLE / RESULT:
  - ev_load: if toggle=A, opa<=data_in and disp_val<={1'b0,data_in}; else opb<=data_in and disp_val<={1'b0,data_in}. Toggle flips. Next state IDLE.
  - ev_calc: working shift regs <= opa/opb, carry<=0, bit counter<=0, busy<=1, next state CALC.
  - ev_clr: opa, opb, disp_val, sum, cout = 0; toggle=A; next state IDLE.
- CALC:
  - Each cycle: s=a0^b0^c; c<=(a0&b0)|(c&(a0^b0)).
  - s is shifted into the MSB of the result reg; the a/b regs shift right.
  - After exactly WIDTH cycles:
    - sum<=result and cout<=c.
    - disp_val<={cout,sum}.
    - done=1 for one cycle.
    - busy<=0.
    - Next state RESULT.
  - Latency: done asserts WIDTH+1 cycles after the cycle ev_calc is high.
  - ev_load and ev_calc are ignored during CALC.
  - ev_clr aborts: same actions as the clear in IDLE, busy<=0, no done pulse.
- sum/cout are held until the next completed calc or a clear. opa/opb are unaffected by calc.
- Overflow: full-width result is {cout,sum}; e.g. WIDTH=8, FF+FF gives 1FE.
- Display:
  - Scan counter counts 0..SCAN_DIV-1.
  - At wrap, the digit index advances 0..NDIG-1 and then back to 0.
  - dig_sel=1<<index; seg_out=font(disp_val[4*index+:4]).
  - The top digit shows the carry (0/1).
  - The scan runs continuously regardless of FSM state.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Extra input op_sub (1 bit) is sampled on ev_calc.
  - If op_sub=1, the b shift reg is loaded with ~opb and the initial carry is 1, so sum=opa-opb mod 2^WIDTH.
  - cout=1 means no borrow.
  - Latency is unchanged.
- When undefined: no op_sub port; addition only; initial carry is 0.

Test Plan (WIDTH=8, DB_CYCLES=4, SCAN_DIV=2):
1. Reset held 3 cycles -> sum=0, cout=0, busy=0, dig_sel=001, seg_out=9'h03f.
2. data_in=0x3A with load press, then data_in=0x45 with load press, then calc press -> busy high for 8 cycles; done pulses 9 cycles after ev_calc; sum=0x7F, cout=0; digits read 0,7,F.
3. A=0xFF, B=0xFF, calc -> sum=0xFE, cout=1, disp_val=0x1FE.
4. Key bouncing low/high every 2 cycles for 20 cycles, then held low 10 cycles -> exactly one load event; 3-cycle low glitch -> no event.
5. Clear pressed 3 cycles into CALC -> busy drops, no done pulse, sum=0, opa=opb=0; next load targets A.
6. With SERIAL_ADDER_SUB_EN defined: A=0x10, B=0x01, op_sub=1 -> sum=0x0F, cout=1. A=0x01, B=0x02 -> sum=0xFF, cout=0.
